bias_stream_loader: RTL and testbench
=====================================

Name: bias_stream_loader

Overview:
- Write-side counterpart to the per-layer bias/weight ROM sources.
- Accepts a parameter tensor as a valid/ready stream, BIAS_PARALLELISM elements per beat, and stores it in an internal RAM.
- Exposes a ROM-compatible read port: address0, ce0, q0, with 2-cycle registered latency.
- Lets encoder layers run from run-time-loaded parameters instead of baked ROM contents.

Parameters:
- BIAS_TENSOR_SIZE_DIM_0, 32: elements in the tensor.
- BIAS_PRECISION_0, 16: bits per element.
- BIAS_PARALLELISM_DIM_0, 1: elements per beat. Must divide BIAS_TENSOR_SIZE_DIM_0.
- DEPTH, BIAS_TENSOR_SIZE_DIM_0/BIAS_PARALLELISM_DIM_0: RAM rows (beats per tensor).
- AWIDTH, $clog2(DEPTH)+1: read address width.
- ROW_W, BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0: RAM row width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- data_in, input, [BIAS_PRECISION_0-1:0] x BIAS_PARALLELISM_DIM_0 (unpacked array): stream elements.
- data_in_valid, input, 1: upstream has a beat.
- data_in_ready, output, 1: loader accepts a beat.
- reload, input, 1: single-cycle request to restart loading.
- load_done, output, 1: full tensor stored.
- address0, input, AWIDTH: read row address.
- ce0, input, 1: read pipeline enable.
- q0, output, ROW_W: read data; element j at bits [BIAS_PRECISION_0*j +: BIAS_PRECISION_0].

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - state=LOAD, wptr=0, load_done=0, data_in_ready=1 (during reset and the first cycle after), q0=0, both read pipeline registers 0.
  - RAM contents are not cleared; they are undefined until written.
- States are LOAD and DONE.
- LOAD:
  - data_in_ready=1.
  - Accept occurs when data_in_valid && data_in_ready. On accept, row wptr <= packed data_in (element j to bits [P*j +: P]), and wptr increments.
  - Accept with wptr==DEPTH-1: row written, wptr wraps to 0, state becomes DONE, load_done=1 from the next cycle.
  - data_in_valid=0: no write, wptr holds (stall). Gaps between beats are allowed.
- DONE:
  - data_in_ready=0; incoming beats are not accepted and not written.
  - load_done=1.
  - reload=1: next cycle state=LOAD, wptr=0, load_done=0, data_in_ready=1.
- reload=1 in LOAD: wptr resets to 0 and any beat presented that same cycle is NOT accepted. data_in_ready is forced to 0 in that cycle: data_in_ready = (state==LOAD) && !reload.
- rst has priority over reload and over any handshake.
- Read path (identical timing to the ROM sources):
  - Stage 1: if ce0, s1 <= (address0 < DEPTH) ? ram[address0] : 0.
  - Stage 2: if ce0, q0 <= s1.
  - Latency is 2 enabled cycles. ce0=0 freezes both stages.
  - Out-of-range addresses (address0 >= DEPTH) return 0.
- Read/write to the same row in the same cycle returns the OLD row contents (read-before-write).
- Reads are legal in either state. Consumers must only rely on data once load_done=1.
- Single clock domain, no combinational path from data_in to q0.
- Target implementation: inferable as a simple dual-port RAM (1W, 1R).

Test Plan:
- Defaults (DEPTH=32).
  - Stimulus: reset, then stream elements 0x0000..0x001F with valid held high.
  - Required: ready high for exactly 32 accepts; load_done rises the cycle after the 32nd accept; ready=0 afterwards.
  - Then reading address0=5 with ce0=1 gives q0=0x0005 two cycles later.
- Backpressure and gaps.
  - Stimulus: valid toggles 1,0,0,1,... with values 0xA000+i.
  - Required: only valid cycles write; row 31 = 0xA01F; load_done asserts only after the 32nd accepted beat.
- PARALLELISM=4 (DEPTH=8).
  - Stimulus: beat k = {4k+3, 4k+2, 4k+1, 4k}.
  - Required: after load, address0=2 gives q0=0x000B_000A_0009_0008, with element 0 in the LSBs.
- Reload and out-of-range.
  - Stimulus: after load_done, pulse reload with valid=1 data=0x7777 in the same cycle.
  - Required: the beat is not accepted; load_done=0; the next accepted beat 0x1234 lands in row 0 (read back 0x1234).
  - Stimulus: address0=32.
  - Required: q0=0.
- Reset mid-load.
  - Stimulus: assert rst after 10 accepted beats.
  - Required: q0=0, load_done=0, wptr=0; a following full load of 32 beats behaves exactly as in the first scenario.
- ce0 stall and read-before-write.
  - Stimulus: ce0=0 for 3 cycles mid-read.
  - Required: q0 holds its value.
  - Stimulus: read row 0 in the cycle row 0 is rewritten after a reload.
  - Required: old value returned, new value returned on the next read.

Source files
------------

// File: rtl/bias_stream_loader.sv
// Stream-loaded parameter RAM with a two-stage registered ROM-style read port.
// A valid/ready stream fills the RAM one row per beat; reload restarts the fill.
module bias_stream_loader #(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PARALLELISM_DIM_0 = 1,
  parameter int DEPTH                  = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
  parameter int AWIDTH                 = $clog2(DEPTH) + 1,
  parameter int ROW_W                  = BIAS_PRECISION_0 * BIAS_PARALLELISM_DIM_0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIAS_PRECISION_0-1:0] data_in [BIAS_PARALLELISM_DIM_0],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  input  logic                        reload,
  output logic                        load_done,
  input  logic [AWIDTH-1:0]           address0,
  input  logic                        ce0,
  output logic [ROW_W-1:0]            q0
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {LOAD, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     wptr;
  logic [ROW_W-1:0]  ram [DEPTH];
  logic [ROW_W-1:0]  row_in;
  logic [ROW_W-1:0]  s1;
  logic              accept;
  logic              rd_in_range;

  // Ready is held high through reset so upstream sees a consistent handshake.
  assign data_in_ready = rst || ((state == LOAD) && !reload);
  assign accept        = !rst && data_in_valid && (state == LOAD) && !reload;
  assign rd_in_range   = address0 < AWIDTH'(DEPTH);

  always_comb begin
    row_in = '0;
    for (int j = 0; j < BIAS_PARALLELISM_DIM_0; j++)
      row_in[BIAS_PRECISION_0*j +: BIAS_PRECISION_0] = data_in[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wptr      <= '0;
      load_done <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (reload) begin
            wptr <= '0;
          end else if (data_in_valid) begin
            if (wptr == IW'(DEPTH - 1)) begin
              wptr      <= '0;
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        DONE: begin
          if (reload) begin
            state     <= LOAD;
            wptr      <= '0;
            load_done <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // No reset on the array so it maps onto a plain 1W/1R block RAM.
  always_ff @(posedge clk) begin
    if (accept)
      ram[wptr] <= row_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q0 <= '0;
    end else if (ce0) begin
      s1 <= rd_in_range ? ram[address0[IW-1:0]] : '0;
      q0 <= s1;
    end
  end

endmodule

// File: tb/tb_bias_stream_loader.sv
// Directed bench for bias_stream_loader: default geometry plus a 4-wide instance.
module tb_bias_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din1 [1];
  logic        valid1, reload1, ce1;
  logic        ready1, done1;
  logic [5:0]  addr1;
  logic [15:0] q1;

  logic [15:0] din4 [4];
  logic        valid4, reload4, ce4;
  logic        ready4, done4;
  logic [3:0]  addr4;
  logic [63:0] q4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [7];

  always #5 clk = ~clk;

  bias_stream_loader u_dut (
    .clk(clk), .rst(rst), .data_in(din1), .data_in_valid(valid1),
    .data_in_ready(ready1), .reload(reload1), .load_done(done1),
    .address0(addr1), .ce0(ce1), .q0(q1)
  );

  bias_stream_loader #(.BIAS_PARALLELISM_DIM_0(4)) u_dut4 (
    .clk(clk), .rst(rst), .data_in(din4), .data_in_valid(valid4),
    .data_in_ready(ready4), .reload(reload4), .load_done(done4),
    .address0(addr4), .ce0(ce4), .q0(q4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Two enabled cycles from address to q0.
  task automatic read1(input logic [5:0] a, input logic [15:0] exp, input string name);
    addr1 = a;
    ce1   = 1'b1;
    tick();
    tick();
    ce1 = 1'b0;
    check(name, 64'(q1), 64'(exp));
  endtask

  // Full 32-beat load; gap idle cycles with garbage data after every beat.
  task automatic load1(input logic [15:0] base, input int gap);
    for (int i = 0; i < 32; i++) begin
      valid1  = 1'b1;
      din1[0] = base + 16'(i);
      #1;
      check("ld_ready", 64'(ready1), 64'd1);
      check("ld_done_early", 64'(done1), 64'd0);
      tick();
      valid1 = 1'b0;
      for (int g = 0; g < gap; g++) begin
        din1[0] = 16'hDEAD;
        tick();
        check("gap_done", 64'(done1), 64'(i == 31));
      end
    end
    check("ld_done", 64'(done1), 64'd1);
    valid1  = 1'b1;
    din1[0] = 16'hBEEF;
    #1;
    check("done_ready", 64'(ready1), 64'd0);
    tick();
    valid1 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{addr: 6'd5,  exp: 16'h0005};
    vecs[1] = '{addr: 6'd0,  exp: 16'h0000};
    vecs[2] = '{addr: 6'd31, exp: 16'h001F};
    vecs[3] = '{addr: 6'd17, exp: 16'h0011};
    vecs[4] = '{addr: 6'd32, exp: 16'h0000};
    vecs[5] = '{addr: 6'd63, exp: 16'h0000};
    vecs[6] = '{addr: 6'd30, exp: 16'h001E};

    rst = 1'b1; valid1 = 0; reload1 = 0; ce1 = 0; addr1 = 0; din1[0] = 0;
    valid4 = 0; reload4 = 0; ce4 = 0; addr4 = 0;
    for (int j = 0; j < 4; j++) din4[j] = 0;
    #1;
    check("rst_ready", 64'(ready1), 64'd1);
    tick();
    tick();
    check("rst_q0", 64'(q1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(ready1), 64'd1);

    // 4-wide instance: beat k carries 4k..4k+3
    for (int k = 0; k < 8; k++) begin
      valid4 = 1'b1;
      for (int j = 0; j < 4; j++) din4[j] = 16'(4*k + j);
      tick();
    end
    valid4 = 1'b0;
    check("p4_done", 64'(done4), 64'd1);
    addr4 = 4'd2; ce4 = 1'b1;
    tick(); tick();
    ce4 = 1'b0;
    check("p4_row2", q4, 64'h000B_000A_0009_0008);

    // Default load with valid held high, then table-driven reads
    load1(16'h0000, 0);
    for (int v = 0; v < 7; v++)
      read1(vecs[v].addr, vecs[v].exp, $sformatf("tbl_rd%0d", v));

    // ce0 stall: q0 must hold row 5 while disabled
    read1(6'd5, 16'h0005, "stall_pre");
    addr1 = 6'd9; ce1 = 1'b1;
    tick();
    check("stall_s1", 64'(q1), 64'h0005);
    ce1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_hold", 64'(q1), 64'h0005);
    end
    ce1 = 1'b1;
    tick();
    ce1 = 1'b0;
    check("stall_resume", 64'(q1), 64'h0009);

    // Reload from DONE with a beat presented in the same cycle
    reload1 = 1'b1; valid1 = 1'b1; din1[0] = 16'h7777;
    #1;
    check("reload_ready", 64'(ready1), 64'd0);
    tick();
    reload1 = 1'b0;
    check("reload_done", 64'(done1), 64'd0);
    din1[0] = 16'h1234;
    #1;
    check("reload_ready_after", 64'(ready1), 64'd1);
    tick();
    valid1 = 1'b0;
    read1(6'd0, 16'h1234, "reload_row0");
    read1(6'd1, 16'h0001, "reload_row1");
    read1(6'd32, 16'h0000, "oob_32");

    // Reload in LOAD, then read row 0 in the cycle it is rewritten
    reload1 = 1'b1; valid1 = 1'b1; din1[0] = 16'h6666;
    #1;
    check("reload_load_ready", 64'(ready1), 64'd0);
    tick();
    reload1 = 1'b0;
    din1[0] = 16'h5555; addr1 = 6'd0; ce1 = 1'b1;
    tick();
    valid1 = 1'b0;
    tick();
    ce1 = 1'b0;
    check("rbw_old", 64'(q1), 64'h1234);
    read1(6'd0, 16'h5555, "rbw_new");

    // Backpressure: one valid cycle then two idle cycles per beat
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load1(16'hA000, 2);
    read1(6'd31, 16'hA01F, "bp_row31");
    read1(6'd0, 16'hA000, "bp_row0");
    read1(6'd12, 16'hA00C, "bp_row12");

    // Reset after 10 accepted beats
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid1 = 1'b1; din1[0] = 16'hB000 + 16'(i);
      tick();
    end
    valid1 = 1'b0;
    read1(6'd3, 16'hB003, "mid_row3");
    rst = 1'b1;
    tick();
    check("mid_rst_q0", 64'(q1), 64'd0);
    check("mid_rst_done", 64'(done1), 64'd0);
    rst = 1'b0;
    load1(16'h0000, 0);
    read1(6'd0, 16'h0000, "mid_row0");
    read1(6'd9, 16'h0009, "mid_row9");
    read1(6'd31, 16'h001F, "mid_row31");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
